// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 256x8 data memory (combinational read, write on
// rising CLK) between the core load/store port (C) and a host/debug port (H).
// Policy: the core has priority, the host is starved for at most STARVE_MAX
// consecutive core grants, and the host has priority while the core is halted.
// Optional host lock: define DMEM_ARB_LOCK_EN to enable the HLOCK state and its
// 255-cycle watchdog. Without it, h_lock is ignored.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until gnt is seen high in the same cycle. The access happens in the gnt cycle
// (writes commit on that CLK edge). Dropping req before gnt cancels the access.
// A granted read returns rdata with rvalid high for exactly the next cycle.
// rdata then holds until the next read response on that port.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          start,
    input  logic          core_halt,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_HALTED = 2'd1
`ifdef DMEM_ARB_LOCK_EN
        ,
        ST_HLOCK  = 2'd2
`endif
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          c_rvalid_q, h_rvalid_q;
    logic [DW-1:0] c_rdata_q, h_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
    // Index of the last permitted HLOCK cycle (count starts at 0 on the first).
    localparam logic [7:0] LOCK_LAST = 8'd254;
    logic [7:0] lock_cnt_q, lock_cnt_d;
`else
    logic unused_lock;
    assign unused_lock = h_lock;
`endif

    // Grant decision from current requests and registered state.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!start) begin
            case (state_q)
                ST_ARB: begin
                    if (c_req && h_req) begin
                        if (starve_q == STARVE_LIM) h_gnt = 1'b1;
                        else                        c_gnt = 1'b1;
                    end else begin
                        c_gnt = c_req;
                        h_gnt = h_req;
                    end
                end
                ST_HALTED: begin
                    h_gnt = h_req;
                    c_gnt = c_req && !h_req;
                end
`ifdef DMEM_ARB_LOCK_EN
                ST_HLOCK: begin
                    h_gnt = h_req;
                end
`endif
                default: ;
            endcase
        end
    end

    // Memory port mux; address and write data hold their last value when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (start) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    // Next state, starvation counter and lock watchdog.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
`ifdef DMEM_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ST_ARB: begin
                if (h_gnt || !h_req)                      starve_d = 4'd0;
                else if (c_gnt && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
                if (core_halt) state_d = ST_HALTED;
`ifdef DMEM_ARB_LOCK_EN
                if (h_gnt && h_lock) begin
                    state_d    = ST_HLOCK;
                    lock_cnt_d = 8'd0;
                end
`endif
            end
            ST_HALTED: begin
                starve_d = 4'd0;
                if (!core_halt) state_d = ST_ARB;
`ifdef DMEM_ARB_LOCK_EN
                if (h_gnt && h_lock) begin
                    state_d    = ST_HLOCK;
                    lock_cnt_d = 8'd0;
                end
`endif
            end
`ifdef DMEM_ARB_LOCK_EN
            ST_HLOCK: begin
                starve_d   = 4'd0;
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (!h_lock || lock_cnt_q == LOCK_LAST)
                    state_d = core_halt ? ST_HALTED : ST_ARB;
            end
`endif
            default: state_d = ST_ARB;
        endcase
    end

    // State registers; reset dominates everything including pending responses.
    always_ff @(posedge CLK) begin
        if (start) begin
            state_q     <= ST_ARB;
            starve_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock watchdog register.
    always_ff @(posedge CLK) begin
        if (start) lock_cnt_q <= 8'd0;
        else       lock_cnt_q <= lock_cnt_d;
    end
`endif

    // Read responses: capture memory data on a read grant, valid next cycle.
    always_ff @(posedge CLK) begin
        if (start) begin
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt && !c_we;
            h_rvalid_q <= h_gnt && !h_we;
            if (c_gnt && !c_we) c_rdata_q <= mem_rdata;
            if (h_gnt && !h_we) h_rdata_q <= mem_rdata;
        end
    end

    assign c_rvalid    = c_rvalid_q;
    assign h_rvalid    = h_rvalid_q;
    assign c_rdata     = c_rdata_q;
    assign h_rdata     = h_rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic, checked
// cycle by cycle against a behavioural model of the arbitration rules and of
// the memory contents.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;

    logic       CLK;
    logic       start, core_halt;
    logic       c_req, c_we, h_req, h_we, h_lock;
    logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
    logic       c_gnt, c_rvalid, h_gnt, h_rvalid, mem_we;
    logic [7:0] c_rdata, h_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] dbg_state;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .start(start), .core_halt(core_halt),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Attached memory: combinational read, write on rising edge.
    logic [7:0] mem_arr [0:255];
    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge CLK) if (mem_we) mem_arr[mem_addr] = mem_wdata;

    // Reference model state
    logic [7:0] ref_mem [0:255];
    logic       m_halted;
    int         m_streak;
    logic       m_crv, m_hrv;
    logic [7:0] m_crd, m_hrd, m_addr, m_wdata;

    // Last expected grants and sampled observations
    logic       g_c, g_h;
    logic       obs_cg, obs_hg, obs_crv, obs_hrv;
    logic [7:0] obs_crd, obs_hrd;

    int n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: predict, sample at negedge, compare, advance the model.
    task automatic step();
        logic       eg_c, eg_h, ewe;
        logic [7:0] ea, ew;
        eg_c = 1'b0;
        eg_h = 1'b0;
        if (!start) begin
            if (m_halted) begin
                if (h_req)      eg_h = 1'b1;
                else if (c_req) eg_c = 1'b1;
            end else if (c_req && h_req) begin
                if (m_streak == STARVE_MAX) eg_h = 1'b1;
                else                        eg_c = 1'b1;
            end else begin
                eg_c = c_req;
                eg_h = h_req;
            end
        end
        ewe = 1'b0;
        ea  = start ? 8'h00 : m_addr;
        ew  = start ? 8'h00 : m_wdata;
        if (eg_c) begin ea = c_addr; ew = c_wdata; ewe = c_we; end
        if (eg_h) begin ea = h_addr; ew = h_wdata; ewe = h_we; end

        @(negedge CLK);
        obs_cg = c_gnt;  obs_hg = h_gnt;
        obs_crv = c_rvalid; obs_hrv = h_rvalid;
        obs_crd = c_rdata;  obs_hrd = h_rdata;
        check_eq("c_gnt", {31'd0, c_gnt}, {31'd0, eg_c});
        check_eq("h_gnt", {31'd0, h_gnt}, {31'd0, eg_h});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        check_eq("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
        check_eq("mem_wdata", {24'd0, mem_wdata}, {24'd0, ew});
        check_eq("c_rvalid", {31'd0, c_rvalid}, {31'd0, m_crv});
        check_eq("h_rvalid", {31'd0, h_rvalid}, {31'd0, m_hrv});
        check_eq("c_rdata", {24'd0, c_rdata}, {24'd0, m_crd});
        check_eq("h_rdata", {24'd0, h_rdata}, {24'd0, m_hrd});

        g_c = eg_c;
        g_h = eg_h;
        if (start) begin
            m_halted = 1'b0; m_streak = 0;
            m_crv = 1'b0; m_hrv = 1'b0; m_crd = 8'h00; m_hrd = 8'h00;
            m_addr = 8'h00; m_wdata = 8'h00;
        end else begin
            m_crv = eg_c && !c_we;
            m_hrv = eg_h && !h_we;
            if (m_crv) m_crd = ref_mem[c_addr];
            if (m_hrv) m_hrd = ref_mem[h_addr];
            if (ewe) ref_mem[ea] = ew;
            m_addr  = ea;
            m_wdata = ew;
            if (m_halted || eg_h || !h_req)          m_streak = 0;
            else if (eg_c && m_streak < STARVE_MAX)  m_streak = m_streak + 1;
            m_halted = core_halt;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
        h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00;
        h_lock = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        m_halted = 1'b0; m_streak = 0;
        m_crv = 1'b0; m_hrv = 1'b0; m_crd = 8'h00; m_hrd = 8'h00;
        m_addr = 8'h00; m_wdata = 8'h00;
        g_c = 1'b0; g_h = 1'b0;
        idle_inputs();
        core_halt = 1'b0;
        start = 1'b1;
        @(posedge CLK);
        #1;

        // Reset, no requests, then one idle cycle.
        step();
        step();
        start = 1'b0;
        step();

        // Host preload, then core read of address 2.
        h_req = 1'b1; h_we = 1'b1;
        h_addr = 8'd0; h_wdata = 8'h00; step();
        check_eq("pre_hgnt0", {31'd0, obs_hg}, 32'd1);
        h_addr = 8'd1; h_wdata = 8'h01; step();
        h_addr = 8'd2; h_wdata = 8'h01; step();
        check_eq("pre_hgnt2", {31'd0, obs_hg}, 32'd1);
        idle_inputs();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd2; step();
        c_req = 1'b0; step();
        check_eq("pre_crv", {31'd0, obs_crv}, 32'd1);
        check_eq("pre_crd", {24'd0, obs_crd}, 32'h01);
        step();

        // Starvation bound: both read continuously.
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'd3;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd6;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("starve_seq", {31'd0, obs_hg}, ((i % 5) == 4) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        step();

        // Halt priority: host reads address 4 while core requests.
        core_halt = 1'b1; step();
        c_req = 1'b1; c_addr = 8'd3;
        h_req = 1'b1; h_addr = 8'd4;
        step();
        check_eq("halt_hgnt", {31'd0, obs_hg}, 32'd1);
        check_eq("halt_cgnt", {31'd0, obs_cg}, 32'd0);
        h_req = 1'b0;
        step();
        check_eq("halt_hrd", {24'd0, obs_hrd}, {24'd0, ref_mem[4]});
        check_eq("halt_cgnt_late", {31'd0, obs_cg}, 32'd1);
        idle_inputs();
        core_halt = 1'b0;
        step();
        step();

        // Same-address conflict: core write 0xAA@5 versus host read @5.
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'd5; c_wdata = 8'hAA;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd5;
        step();
        check_eq("conf_cgnt", {31'd0, obs_cg}, 32'd1);
        c_req = 1'b0;
        step();
        check_eq("conf_hgnt", {31'd0, obs_hg}, 32'd1);
        h_req = 1'b0;
        step();
        check_eq("conf_hrv", {31'd0, obs_hrv}, 32'd1);
        check_eq("conf_hrd", {24'd0, obs_hrd}, 32'hAA);

        // Randomized traffic with occasional halts, drops and resets.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) core_halt = ~core_halt;
            if (c_req && !g_c) begin
                if ($urandom_range(0, 9) == 0) c_req = 1'b0;
            end else begin
                c_req   = ($urandom_range(0, 2) != 0);
                c_we    = 1'($urandom_range(0, 1));
                c_addr  = 8'($urandom_range(0, 7));
                c_wdata = 8'($urandom);
            end
            if (h_req && !g_h) begin
                if ($urandom_range(0, 9) == 0) h_req = 1'b0;
            end else begin
                h_req   = ($urandom_range(0, 2) != 0);
                h_we    = 1'($urandom_range(0, 1));
                h_addr  = 8'($urandom_range(0, 7));
                h_wdata = 8'($urandom);
            end
`ifdef DMEM_ARB_LOCK_EN
            h_lock = 1'b0;
`else
            h_lock = 1'($urandom_range(0, 1));
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single 256x8 data memory (combinational read, write on rising CLK) between two requesters: the core load/store path (port C) and a host/debug loader (port H).
- The host uses port H to preload operands (e.g. dividend at 0-1, divisor at 2) and to read results (quotient at 4-6) without poking memory hierarchically.
- Sits between the core and data memory in TopLevel.
- Policy: core priority, bounded host starvation, optional host lock.

Parameters:
- AW, 8, address width (memory depth 2**AW).
- DW, 8, data width.
- STARVE_MAX, 4, consecutive core grants with host waiting before the host is forced a slot (1..15).

Ports:
- CLK  in  1  clock.
- start  in  1  synchronous active-high reset.
- core_halt  in  1  core halted; host becomes priority requester.
- c_req  in  1  core request; held with address/data until c_gnt.
- c_we  in  1  1=write, 0=read.
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data valid (one cycle after read grant).
- c_rdata  out  DW  core read data.
- h_req, h_we, h_addr, h_wdata  in  1/1/AW/DW  host request, same rules as core.
- h_lock  in  1  host lock request (feature only; ignored otherwise).
- h_gnt, h_rvalid  out  1  host grant / read valid.
- h_rdata  out  DW  host read data.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data (combinational on mem_addr).

Behaviour:
- Reset (start=1 at CLK edge):
  - State to ARB, starve counter 0.
  - c_rvalid, h_rvalid = 0; c_rdata, h_rdata = 0.
  - c_gnt, h_gnt, mem_we = 0 while start=1, regardless of requests.
  - mem_addr = 0, mem_wdata = 0.
- At most one grant per cycle; grant is combinational from current requests and registered state.
- Granted port drives mem_addr/mem_we/mem_wdata that cycle; write commits on that edge.
- No grant: mem_we = 0, mem_addr/mem_wdata hold their last value.
- Read grant: mem_rdata registered into that port's rdata; rvalid=1 for exactly the next cycle. rdata holds until the next read response.
- Write grant: no rvalid.
- Requester holds req/we/addr/wdata stable until gnt. Dropping req before gnt is legal and means no access.
- Back-to-back grants to the same port are allowed every cycle; read latency is fixed at 1.
- States:
  - ARB (normal).
    - Only one port requests: it is granted.
    - Both request: core wins unless starve counter == STARVE_MAX, in which case host wins.
    - Counter increments on each core grant while h_req=1; saturates at STARVE_MAX.
    - Counter clears on any host grant, or when h_req=0.
    - core_halt=1 → HALTED.
  - HALTED.
    - Host has priority; core granted only when h_req=0.
    - core_halt=0 → ARB, counter cleared.
  - HLOCK: feature only, see below.
- Same-cycle conflict on the same address: only the granted access occurs. The loser is served in a later cycle and sees the updated value.
- Reset mid-operation: any grant in the reset cycle is suppressed (no write occurs); pending rvalid is cleared.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With macro:
  - In ARB or HALTED, a host grant while h_lock=1 → HLOCK.
  - HLOCK: only the host is granted and c_gnt=0, even if h_req=0.
  - HLOCK exits when h_lock=0 at a clock edge, to ARB (or to HALTED if core_halt=1); counter cleared on exit.
  - HLOCK lasts at most 255 cycles; a watchdog counter forces exit to ARB/HALTED on the 256th cycle.
- Without macro: h_lock ignored, no HLOCK state, no watchdog counter.

Test Plan:
- Reset, no requests:
  - Stimulus: start=1 for 2 cycles, then 0.
  - Response: all gnt/rvalid/mem_we = 0; mem_addr=0.
- Host preload then core read:
  - Stimulus: host writes 0x00@0, 0x01@1, 0x01@2; core then reads addr 2.
  - Response: h_gnt one cycle each; c_rvalid the cycle after c_gnt with c_rdata=0x01.
- Starvation bound:
  - Stimulus: c_req and h_req held high, STARVE_MAX=4.
  - Response: grant pattern C,C,C,C,H,C,C,C,C,H…; host wait never exceeds 4 cycles.
- Halt priority:
  - Stimulus: core_halt=1 with both requesting; host reads addr 4.
  - Response: h_gnt immediately; h_rdata = memory[4] next cycle; c_gnt=0 until h_req drops.
- Same-address conflict:
  - Stimulus: core writes 0xAA@5 and host reads @5 in the same cycle.
  - Response: core granted first; host granted next cycle and reads 0xAA.
- With DMEM_ARB_LOCK_EN:
  - Stimulus: host grant with h_lock=1, h_lock held 10 cycles, core requesting throughout.
  - Response: c_gnt=0 for the lock duration; core granted the first cycle after h_lock=0.
  - Stimulus: h_lock held 300 cycles.
  - Response: forced exit after 256 cycles.
